mem_arbiter: RTL and testbench

// - Sits between the 3-stage Riscv151 core and a single shared memory port; serializes the

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Serializes the Riscv151 core's icache and dcache requests onto a single
//   valid/ready memory request channel. At most one memory transaction is in
//   flight. When both caches request together, the dcache op goes first.
//   The core is frozen (stall) whenever the arbiter is not idle. Read data is
//   held in registers and is valid in the first cycle stall is low again.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   icache_*         fetch request in (addr, re), registered fetch data out
//   dcache_*         load/store request in (addr, re, we mask, din),
//                    registered load data out
//   stall            freeze core, decoded from state
//   mem_req_*        request channel (valid/ready, rw, addr, data, mask)
//   mem_resp_*       in-order read response (valid, data)
//   mem_err          sticky flag: a read timed out
//   stall_cycles     stall cycle counter
//
// Configuration
//   MEM_ARB_STALL_CNT_EN  when defined, stall_cycles counts clocks with
//                         stall = 1 (saturating); otherwise tied to zero.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AWIDTH-1:0]   icache_addr,
  input  logic                icache_re,
  output logic [DWIDTH-1:0]   icache_dout,
  input  logic [AWIDTH-1:0]   dcache_addr,
  input  logic                dcache_re,
  input  logic [DWIDTH/8-1:0] dcache_we,
  input  logic [DWIDTH-1:0]   dcache_din,
  output logic [DWIDTH-1:0]   dcache_dout,
  output logic                stall,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [AWIDTH-1:0]   mem_req_addr,
  output logic [DWIDTH-1:0]   mem_req_data,
  output logic [DWIDTH/8-1:0] mem_req_mask,
  input  logic                mem_resp_valid,
  input  logic [DWIDTH-1:0]   mem_resp_data,
  output logic                mem_err,
  output logic [31:0]         stall_cycles
);

  localparam int MW = DWIDTH / 8;
  // Counter wide enough to hold TIMEOUT-1; a 1-bit dummy when timeouts are off.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]     TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [DWIDTH-1:0] BAD  = DWIDTH'(32'hDEADBEEF);

  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT} state_t;

  state_t            state;
  logic              ipend;
  logic              cap_rw;
  logic [AWIDTH-1:0] cap_iaddr;
  logic [AWIDTH-1:0] cap_daddr;
  logic [DWIDTH-1:0] cap_din;
  logic [MW-1:0]     cap_mask;
  logic [TW-1:0]     tcnt;
  logic              timed_out;
  logic              d_op;

  assign d_op      = dcache_re | (|dcache_we);
  // The count reaching TIMEOUT-1 means this is the TIMEOUT-th wait cycle.
  assign timed_out = (TIMEOUT != 0) && (tcnt == TLIM);

  // NOTE: every register below is assigned with <= so that all state updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ipend       <= 1'b0;
      cap_rw      <= 1'b0;
      cap_iaddr   <= '0;
      cap_daddr   <= '0;
      cap_din     <= '0;
      cap_mask    <= '0;
      tcnt        <= '0;
      icache_dout <= '0;
      dcache_dout <= '0;
      mem_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (icache_re | d_op) begin
            ipend     <= icache_re;
            cap_rw    <= |dcache_we;
            cap_iaddr <= icache_addr;
            cap_daddr <= dcache_addr;
            cap_din   <= dcache_din;
            cap_mask  <= dcache_we;   // zero for loads, so reads carry mask 0
            state     <= d_op ? D_REQ : I_REQ;
          end
        end
        D_REQ: begin
          if (mem_req_ready) begin
            if (cap_rw) begin
              // Stores get no response; move straight on.
              state <= ipend ? I_REQ : IDLE;
            end else begin
              state <= D_WAIT;
              tcnt  <= '0;
            end
          end
        end
        D_WAIT: begin
          // A response in the same cycle as the timeout wins.
          if (mem_resp_valid) begin
            dcache_dout <= mem_resp_data;
            state       <= ipend ? I_REQ : IDLE;
          end else if (timed_out) begin
            dcache_dout <= BAD;
            mem_err     <= 1'b1;
            state       <= ipend ? I_REQ : IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        I_REQ: begin
          if (mem_req_ready) begin
            state <= I_WAIT;
            tcnt  <= '0;
          end
        end
        I_WAIT: begin
          if (mem_resp_valid) begin
            icache_dout <= mem_resp_data;
            state       <= IDLE;
          end else if (timed_out) begin
            icache_dout <= BAD;
            mem_err     <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request channel is decoded from state and captured registers only, so the
  // fields cannot move while a request waits for ready.
  assign stall         = (state != IDLE);
  assign mem_req_valid = (state == D_REQ) || (state == I_REQ);
  assign mem_req_rw    = (state == D_REQ) && cap_rw;
  assign mem_req_addr  = (state == I_REQ) ? cap_iaddr : cap_daddr;
  assign mem_req_data  = cap_din;
  assign mem_req_mask  = (state == D_REQ) ? cap_mask : '0;

`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scoreboard bench for mem_arbiter. Each operation pushes its
//   expected memory requests and its expected completion (dout values, error
//   flag, stall length) into queues; two monitors pop and compare when the DUT
//   accepts a request or drops stall. A small memory responder drives ready
//   (optionally held low) and answers reads one cycle after accept.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_err;
  logic [31:0] stall_cycles;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    logic [31:0] idout;
    logic [31:0] ddout;
    logic        err;
    int          len;
  } cmp_t;

  req_t exp_req[$];
  cmp_t exp_cmp[$];

  int   n_vec  = 0;
  int   n_miss = 0;

  // Responder controls, changed by the main sequence at negedges only.
  int   ready_lo   = 0;
  bit   resp_en    = 1'b1;
  bit   force_resp = 1'b0;

  // Reference model of the core-visible registers.
  logic [31:0] m_i   = '0;
  logic [31:0] m_d   = '0;
  logic        m_err = 1'b0;

  function automatic logic [31:0] resp_for(logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'h0000_0013 : {a[15:0], 16'hA5C3};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: acts just after each rising edge.
  // ---------------------------------------------------------------------------
  initial begin : responder
    bit          last_valid;
    bit          last_rd;
    logic [31:0] last_addr;
    int          lo_ctr;
    bit          acc_any;
    bit          acc_rd;
    last_valid     = 1'b0;
    last_rd        = 1'b0;
    last_addr      = '0;
    lo_ctr         = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_valid     = 1'b0;
        last_rd        = 1'b0;
        lo_ctr         = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
      end else begin
        acc_any = last_valid && mem_req_ready;
        acc_rd  = last_rd && mem_req_ready;
        mem_resp_valid = (acc_rd && resp_en) || force_resp;
        mem_resp_data  = force_resp ? 32'h1234_5678 :
                         (acc_rd ? resp_for(last_addr) : 32'h0);
        if (acc_any) lo_ctr = 0;
        if (mem_req_valid) begin
          if (lo_ctr < ready_lo) begin
            mem_req_ready = 1'b0;
            lo_ctr++;
          end else begin
            mem_req_ready = 1'b1;
          end
        end else begin
          mem_req_ready = 1'b0;
          lo_ctr        = 0;
        end
        last_valid = mem_req_valid;
        last_rd    = mem_req_valid && !mem_req_rw;
        last_addr  = mem_req_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request monitor: fields must match the queue head on every valid cycle
  // (which also proves stability while ready is low); pop on accept.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : req_mon
    req_t r;
    if (!reset && mem_req_valid) begin
      check("req pending", exp_req.size() > 0, 1);
      if (exp_req.size() > 0) begin
        r = exp_req[0];
        check("req rw",   mem_req_rw,   r.rw);
        check("req addr", mem_req_addr, r.addr);
        check("req mask", mem_req_mask, r.mask);
        if (r.rw) check("req data", mem_req_data, r.data);
        if (mem_req_ready) void'(exp_req.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion monitor: when stall falls, compare douts, error and stall length.
  // ---------------------------------------------------------------------------
  int run = 0;

  always @(negedge clk) begin : cmp_mon
    cmp_t c;
    if (reset) begin
      run = 0;
    end else if (stall) begin
      run++;
    end else if (run > 0) begin
      check("cmp pending", exp_cmp.size() > 0, 1);
      if (exp_cmp.size() > 0) begin
        c = exp_cmp.pop_front();
        check("icache_dout", icache_dout, c.idout);
        check("dcache_dout", dcache_dout, c.ddout);
        check("mem_err",     mem_err,     c.err);
        check("stall len",   run,         c.len);
      end
      run = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // One core operation. Entered and left at a negedge with stall low.
  // ---------------------------------------------------------------------------
  task automatic run_op(bit i_re, logic [31:0] i_addr, bit d_re,
                        logic [3:0] d_we, logic [31:0] d_addr,
                        logic [31:0] d_din);
    int len  = 0;
    bit done = 1'b0;
    if (d_re || (d_we != 4'b0)) begin
      exp_req.push_back('{rw: (d_we != 4'b0), addr: d_addr, data: d_din,
                          mask: d_we});
      len += 1 + ready_lo;
      if (d_we == 4'b0) begin
        len += resp_en ? 1 : TIMEOUT;
        m_d  = resp_en ? resp_for(d_addr) : 32'hDEADBEEF;
        if (!resp_en) m_err = 1'b1;
      end
    end
    if (i_re) begin
      exp_req.push_back('{rw: 1'b0, addr: i_addr, data: 32'h0, mask: 4'b0});
      len += 1 + ready_lo + (resp_en ? 1 : TIMEOUT);
      m_i  = resp_en ? resp_for(i_addr) : 32'hDEADBEEF;
      if (!resp_en) m_err = 1'b1;
    end
    exp_cmp.push_back('{idout: m_i, ddout: m_d, err: m_err, len: len});

    icache_re   = i_re;
    icache_addr = i_addr;
    dcache_re   = d_re;
    dcache_we   = d_we;
    dcache_addr = d_addr;
    dcache_din  = d_din;
    @(posedge clk);
    #1;
    icache_re = 1'b0;
    dcache_re = 1'b0;
    dcache_we = 4'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    check("op completes", done, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int exp_cnt;
    reset       = 1'b1;
    icache_re   = 1'b0;
    icache_addr = '0;
    dcache_re   = 1'b0;
    dcache_we   = 4'b0;
    dcache_addr = '0;
    dcache_din  = '0;
    repeat (2) @(negedge clk);
    check("rst stall",        stall,         0);
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst mem_err",      mem_err,       0);
    check("rst icache_dout",  icache_dout,   0);
    check("rst dcache_dout",  dcache_dout,   0);
    check("rst stall_cycles", stall_cycles,  0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only: 2 stall cycles, icache_dout = 0x13.
    run_op(1'b1, 32'h1000, 1'b0, 4'b0000, 32'h0, 32'h0);
    // Store (mask 0011) plus fetch: store first, dcache_dout untouched.
    run_op(1'b1, 32'h1004, 1'b0, 4'b0011, 32'h2004, 32'hAABBCCDD);
    // Load plus fetch with ready held low 5 cycles on each request.
    ready_lo = 5;
    run_op(1'b1, 32'h1008, 1'b1, 4'b0000, 32'h3000, 32'h0);
    ready_lo = 0;
    // Load only.
    run_op(1'b0, 32'h0, 1'b1, 4'b0000, 32'h3004, 32'h0);
    // Fetch with no response: times out after TIMEOUT wait cycles.
    resp_en = 1'b0;
    run_op(1'b1, 32'h100C, 1'b0, 4'b0000, 32'h0, 32'h0);
    resp_en = 1'b1;
    // Normal fetch afterwards: mem_err stays set.
    run_op(1'b1, 32'h1010, 1'b0, 4'b0000, 32'h0, 32'h0);
    // Store with re also high: the mask makes it a store; no fetch.
    run_op(1'b0, 32'h0, 1'b1, 4'b1111, 32'h4000, 32'h0BAD_F00D);

    // Reset during D_WAIT, then a late response in IDLE.
    resp_en = 1'b0;
    exp_req.push_back('{rw: 1'b0, addr: 32'h3008, data: 32'h0, mask: 4'b0});
    dcache_re   = 1'b1;
    dcache_addr = 32'h3008;
    @(posedge clk);
    #1;
    dcache_re = 1'b0;
    repeat (2) @(negedge clk);
    check("in D_WAIT stall", stall, 1);
    reset = 1'b1;
    #1;
    check("async rst stall", stall, 0);
    @(negedge clk);
    reset   = 1'b0;
    resp_en = 1'b1;
    m_i = '0;
    m_d = '0;
    m_err = 1'b0;
    check("post-rst icache_dout",  icache_dout,  0);
    check("post-rst dcache_dout",  dcache_dout,  0);
    check("post-rst mem_err",      mem_err,      0);
    check("post-rst stall_cycles", stall_cycles, 0);
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("late resp stall",       stall,         0);
    check("late resp valid",       mem_req_valid, 0);
    check("late resp icache_dout", icache_dout,   0);
    check("late resp dcache_dout", dcache_dout,   0);

    // Three back-to-back 2-stall fetches from a fresh reset.
    run_op(1'b1, 32'h1000, 1'b0, 4'b0000, 32'h0, 32'h0);
    run_op(1'b1, 32'h2000, 1'b0, 4'b0000, 32'h0, 32'h0);
    run_op(1'b1, 32'h2004, 1'b0, 4'b0000, 32'h0, 32'h0);
`ifdef MEM_ARB_STALL_CNT_EN
    exp_cnt = 6;
`else
    exp_cnt = 0;
`endif
    check("stall_cycles", stall_cycles, exp_cnt);

    repeat (2) @(negedge clk);
    check("req queue drained", exp_req.size(), 0);
    check("cmp queue drained", exp_cmp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
